br_ram_addr_data_wr_pipe: RTL and testbench



---
 rtl/br_ram_pkg.sv | 24 ++
 rtl/br_ram_wr_pipe_stage.sv | 41 ++++
 rtl/br_ram_addr_data_wr_pipe.sv | 137 +++++++++++++
 tb/tb_br_ram_addr_data_wr_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/br_ram_pkg.sv
// Shared helpers for the tiled-RAM read/write pipes: tile decode and derived widths.
package br_ram_pkg;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int tile_addr_width(input int tile_depth);
        return $clog2(max2(2, tile_depth));
    endfunction

    function automatic int tile_index(input int addr, input int tile_depth);
        return addr / tile_depth;
    endfunction

    function automatic int tile_local_addr(input int addr, input int tile_depth);
        return addr % tile_depth;
    endfunction

    function automatic logic addr_in_range(input int addr, input int depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/br_ram_wr_pipe_stage.sv
// Valid-qualified register pipeline; payload flops load only under valid.
module br_ram_wr_pipe_stage #(
    parameter int NumStages = 1,
    parameter int Width     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    if (NumStages == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_pipe
        logic [NumStages-1:0]            valid_q;
        logic [NumStages-1:0][Width-1:0] data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q[0] <= valid_i;
                if (valid_i) data_q[0] <= data_i;
                for (int i = 1; i < NumStages; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) data_q[i] <= data_q[i-1];
                end
            end
        end

        assign valid_o = valid_q[NumStages-1];
        assign data_o  = data_q[NumStages-1];
    end

endmodule

// File: rtl/br_ram_addr_data_wr_pipe.sv
// Tiled-RAM write fan-out: depth decode, width slice, optional stages on both sides.
// Macros: BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN (per-tile enables), BR_DISABLE_INTG_CHECKS.
module br_ram_addr_data_wr_pipe
    import br_ram_pkg::*;
#(
    parameter int Depth       = 2,
    parameter int Width       = 1,
    parameter int DepthTiles  = 1,
    parameter int WidthTiles  = 1,
    parameter int DepthStages = 0,
    parameter int WidthStages = 0,
    localparam int AddrWidth     = $clog2(Depth),
    localparam int TileDepth     = Depth / DepthTiles,
    localparam int TileAddrWidth = tile_addr_width(TileDepth),
    localparam int TileWidth     = Width / WidthTiles
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   wr_valid,
    input  logic [AddrWidth-1:0]                                   wr_addr,
    input  logic [Width-1:0]                                       wr_data,
`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
    input  logic [WidthTiles-1:0]                                  wr_tile_en,
`endif
    output logic [DepthTiles-1:0][WidthTiles-1:0]                  tile_wr_valid,
    output logic [DepthTiles-1:0][WidthTiles-1:0][TileAddrWidth-1:0] tile_wr_addr,
    output logic [DepthTiles-1:0][WidthTiles-1:0][TileWidth-1:0]   tile_wr_data
);

    localparam int Latency = DepthStages + WidthStages;

    logic                  a_valid;
    logic [AddrWidth-1:0]  a_addr;
    logic [Width-1:0]      a_data;
    logic [WidthTiles-1:0] a_tile_en;

`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
    localparam int CmdWidth = WidthTiles + AddrWidth + Width;
    logic [CmdWidth-1:0] a_cmd_in;
    logic [CmdWidth-1:0] a_cmd_out;
    assign a_cmd_in = {wr_tile_en, wr_addr, wr_data};
    assign {a_tile_en, a_addr, a_data} = a_cmd_out;
`else
    localparam int CmdWidth = AddrWidth + Width;
    logic [CmdWidth-1:0] a_cmd_in;
    logic [CmdWidth-1:0] a_cmd_out;
    assign a_cmd_in = {wr_addr, wr_data};
    assign {a_addr, a_data} = a_cmd_out;
    assign a_tile_en = '1;
`endif

    br_ram_wr_pipe_stage #(
        .NumStages(DepthStages),
        .Width    (CmdWidth)
    ) u_stage_a (
        .clk    (clk),
        .rst    (rst),
        .valid_i(wr_valid),
        .data_i (a_cmd_in),
        .valid_o(a_valid),
        .data_o (a_cmd_out)
    );

    // Out-of-range commands are dropped here, after stage A.
    logic                     a_ok;
    logic [TileAddrWidth-1:0] a_local;
    assign a_ok    = a_valid && addr_in_range(32'(a_addr), Depth);
    assign a_local = TileAddrWidth'(tile_local_addr(32'(a_addr), TileDepth));

    for (genvar d = 0; d < DepthTiles; d++) begin : g_row
        logic row_valid;
        assign row_valid = a_ok && (tile_index(32'(a_addr), TileDepth) == d);

        for (genvar w = 0; w < WidthTiles; w++) begin : g_col
            logic [TileAddrWidth+TileWidth-1:0] b_in;
            logic [TileAddrWidth+TileWidth-1:0] b_out;
            assign b_in = {a_local, a_data[w*TileWidth +: TileWidth]};

            br_ram_wr_pipe_stage #(
                .NumStages(WidthStages),
                .Width    (TileAddrWidth + TileWidth)
            ) u_stage_b (
                .clk    (clk),
                .rst    (rst),
                .valid_i(row_valid && a_tile_en[w]),
                .data_i (b_in),
                .valid_o(tile_wr_valid[d][w]),
                .data_o (b_out)
            );

            assign {tile_wr_addr[d][w], tile_wr_data[d][w]} = b_out;
        end
    end

`ifndef SYNTHESIS
    logic                  in_ok;
    logic                  exp_any;
    logic [DepthTiles-1:0] row_any;
    logic [DepthTiles-1:0] row_full;
    assign in_ok = wr_valid && addr_in_range(32'(wr_addr), Depth);

    for (genvar d = 0; d < DepthTiles; d++) begin : g_chk_row
        assign row_any[d]  = |tile_wr_valid[d];
        assign row_full[d] = &tile_wr_valid[d];
    end

    if (Latency == 0) begin : g_exp0
        assign exp_any = in_ok;
    end else begin : g_expn
        // Shadow of accepted in-range commands, cleared by reset like the pipe.
        logic [Latency-1:0] inflight_d;
        logic [Latency-1:0] inflight_q;
        assign inflight_d = Latency'({inflight_q, in_ok});
        always_ff @(posedge clk or posedge rst) begin
            if (rst) inflight_q <= '0;
            else     inflight_q <= inflight_d;
        end
        assign exp_any = inflight_q[Latency-1];
    end

    a_one_row: assert property (@(posedge clk) disable iff (rst)
        $onehot0(row_any));
    a_causal: assert property (@(posedge clk) disable iff (rst)
        !exp_any |-> (row_any == '0));
`ifndef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
    a_propagate: assert property (@(posedge clk) disable iff (rst)
        exp_any |-> (row_any != '0));
    a_lockstep: assert property (@(posedge clk) disable iff (rst)
        row_any == row_full);
`endif
`ifndef BR_DISABLE_INTG_CHECKS
    a_intg_range: assert property (@(posedge clk) disable iff (rst)
        wr_valid |-> addr_in_range(32'(wr_addr), Depth));
`endif
`endif

endmodule

// File: tb/tb_br_ram_addr_data_wr_pipe.sv
// Directed bench: 8x8 RAM in 2x2 tiles, pipelined, combinational and Depth=6 variants.
module tb_br_ram_addr_data_wr_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       d6_valid;
    logic [2:0] d6_addr;
    logic [7:0] d6_data;
`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
    logic [1:0] wr_tile_en;
`endif

    logic [1:0][1:0]      m_v, c_v, s_v;
    logic [1:0][1:0][1:0] m_a, c_a, s_a;
    logic [1:0][1:0][3:0] m_d, c_d, s_d;

    int n_chk  = 0;
    int n_fail = 0;

    br_ram_addr_data_wr_pipe #(
        .Depth(8), .Width(8), .DepthTiles(2), .WidthTiles(2),
        .DepthStages(1), .WidthStages(1)
    ) u_main (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
        .wr_tile_en(wr_tile_en),
`endif
        .tile_wr_valid(m_v), .tile_wr_addr(m_a), .tile_wr_data(m_d)
    );

    br_ram_addr_data_wr_pipe #(
        .Depth(8), .Width(8), .DepthTiles(2), .WidthTiles(2),
        .DepthStages(0), .WidthStages(0)
    ) u_comb (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
        .wr_tile_en(wr_tile_en),
`endif
        .tile_wr_valid(c_v), .tile_wr_addr(c_a), .tile_wr_data(c_d)
    );

    br_ram_addr_data_wr_pipe #(
        .Depth(6), .Width(8), .DepthTiles(2), .WidthTiles(2),
        .DepthStages(1), .WidthStages(1)
    ) u_d6 (
        .clk(clk), .rst(rst),
        .wr_valid(d6_valid), .wr_addr(d6_addr), .wr_data(d6_data),
`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
        .wr_tile_en(2'b11),
`endif
        .tile_wr_valid(s_v), .tile_wr_addr(s_a), .tile_wr_data(s_d)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Valid bit t = d*2+w; addr/data checked only on tiles expected to strobe.
    task automatic check_tiles(input string nm, input logic [3:0] v,
                               input logic [7:0] a, input logic [15:0] dd,
                               input logic [3:0] ev, input logic [1:0] ea,
                               input logic [7:0] ed);
        check({nm, " valid"}, 32'(v), 32'(ev));
        for (int t = 0; t < 4; t++) begin
            if (ev[t]) begin
                check($sformatf("%s addr t%0d", nm, t), 32'(a[t*2 +: 2]), 32'(ea));
                check($sformatf("%s data t%0d", nm, t), 32'(dd[t*4 +: 4]),
                      32'(ed[(t%2)*4 +: 4]));
            end
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [2:0] a;
        logic [7:0] d;
        logic [3:0] cv;
        logic [3:0] ev;
        logic [1:0] ea;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [12];

    logic [2:0] s6_a  [5];
    logic [7:0] s6_d  [5];
    logic [3:0] s6_ev [5];
    logic [1:0] s6_ea [5];
    logic [7:0] s6_ed [5];

    initial begin
        // v, addr, data, comb valid, main valid, main local addr, main data
        tbl[0]  = '{1'b1, 3'd5, 8'hA5, 4'b1100, 4'b0000, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 3'd0, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00};
        tbl[2]  = '{1'b1, 3'd0, 8'h11, 4'b0011, 4'b1100, 2'd1, 8'hA5};
        tbl[3]  = '{1'b1, 3'd4, 8'h22, 4'b1100, 4'b0000, 2'd0, 8'h00};
        tbl[4]  = '{1'b1, 3'd3, 8'h33, 4'b0011, 4'b0011, 2'd0, 8'h11};
        tbl[5]  = '{1'b0, 3'd0, 8'h00, 4'b0000, 4'b1100, 2'd0, 8'h22};
        tbl[6]  = '{1'b0, 3'd0, 8'h00, 4'b0000, 4'b0011, 2'd3, 8'h33};
        tbl[7]  = '{1'b1, 3'd7, 8'hFF, 4'b1100, 4'b0000, 2'd0, 8'h00};
        tbl[8]  = '{1'b1, 3'd6, 8'h3C, 4'b1100, 4'b0000, 2'd0, 8'h00};
        tbl[9]  = '{1'b0, 3'd0, 8'h00, 4'b0000, 4'b1100, 2'd3, 8'hFF};
        tbl[10] = '{1'b0, 3'd0, 8'h00, 4'b0000, 4'b1100, 2'd2, 8'h3C};
        tbl[11] = '{1'b0, 3'd0, 8'h00, 4'b0000, 4'b0000, 2'd0, 8'h00};

        // Depth=6: TileDepth=3, so 5 -> row1/2, 3 -> row1/0, 2 -> row0/2.
        s6_a  = '{3'd5, 3'd3, 3'd2, 3'd0, 3'd0};
        s6_d  = '{8'h96, 8'h5A, 8'hC3, 8'h00, 8'h00};
        s6_ev = '{4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0011};
        s6_ea = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2};
        s6_ed = '{8'h00, 8'h00, 8'h96, 8'h5A, 8'hC3};

        rst = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        d6_valid = 1'b0; d6_addr = '0; d6_data = '0;
`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
        wr_tile_en = 2'b11;
`endif
        #12;
        check("reset valid", 32'(m_v), 32'd0);
        check("reset addr",  32'(m_a), 32'd0);
        check("reset data",  32'(m_d), 32'd0);
        check("reset d6 valid", 32'(s_v), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_valid = tbl[i].v; wr_addr = tbl[i].a; wr_data = tbl[i].d;
            #1;
            check_tiles($sformatf("main[%0d]", i), m_v, m_a, m_d,
                        tbl[i].ev, tbl[i].ea, tbl[i].ed);
            check_tiles($sformatf("comb[%0d]", i), c_v, c_a, c_d,
                        tbl[i].cv, tbl[i].a[1:0], tbl[i].d);
        end

        // Asynchronous reset with two commands in flight.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'h12;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 8'h34;
        @(posedge clk);
        #1;
        check("inflight valid", 32'(m_v), 32'b0011);
        wr_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async rst valid", 32'(m_v), 32'd0);
        check("async rst addr",  32'(m_a), 32'd0);
        check("async rst data",  32'(m_d), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("post rst idle %0d", i), 32'(m_v), 32'd0);
        end
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h5C;
        #1;
        check("post rst lat0", 32'(m_v), 32'd0);
        check_tiles("comb addr2", c_v, c_a, c_d, 4'b0011, 2'd2, 8'h5C);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("post rst lat1", 32'(m_v), 32'd0);
        @(negedge clk);
        #1;
        check_tiles("post rst lat2", m_v, m_a, m_d, 4'b0011, 2'd2, 8'h5C);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d6_valid = (i < 3); d6_addr = s6_a[i]; d6_data = s6_d[i];
            #1;
            check_tiles($sformatf("d6[%0d]", i), s_v, s_a, s_d,
                        s6_ev[i], s6_ea[i], s6_ed[i]);
        end
        @(negedge clk);
        d6_valid = 1'b0;

`ifdef BR_DISABLE_INTG_CHECKS
        @(negedge clk);
        d6_valid = 1'b1; d6_addr = 3'd7; d6_data = 8'hEE;
        @(negedge clk);
        d6_valid = 1'b1; d6_addr = 3'd6; d6_data = 8'hDD;
        @(negedge clk);
        d6_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("d6 oob drop %0d", i), 32'(s_v), 32'd0);
            @(negedge clk);
        end
`endif

`ifdef BR_RAM_ADDR_DATA_WR_PIPE_PARTIAL_WR_EN
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 8'h77; wr_tile_en = 2'b10;
        #1;
        check_tiles("comb partial", c_v, c_a, c_d, 4'b1000, 2'd2, 8'h77);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'h99; wr_tile_en = 2'b00;
        @(negedge clk);
        wr_valid = 1'b0; wr_tile_en = 2'b11;
        #1;
        check_tiles("main partial", m_v, m_a, m_d, 4'b1000, 2'd2, 8'h77);
        @(negedge clk);
        #1;
        check("main en none", 32'(m_v), 32'd0);
`endif

        wr_valid = 1'b0;
        d6_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("final main valid", 32'(m_v), 32'd0);
        check("final comb valid", 32'(c_v), 32'd0);
        check("final d6 valid",   32'(s_v), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
